// File: rtl/mem_nr_mw_helper_if.sv
// mem_nr_mw_helper_if: request/response bundle for the multi-port memory helper.
//   r_enable/r_index          : per-port read requests (index is 64 bits per port)
//   r_data/r_valid            : per-port read responses
//   w_enable/w_index/w_data/w_mask : per-port bit-masked write requests
//   oob_err/wr_count          : sticky out-of-range flag, saturating write counter
//   modport master drives requests, modport slave (the helper) drives responses.
interface mem_nr_mw_helper_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned N_R    = 2,
    parameter int unsigned N_W    = 2
);
    localparam int unsigned IW = 64;

    logic [N_R-1:0]        r_enable;
    logic [N_R*IW-1:0]     r_index;
    logic [N_R*DATA_W-1:0] r_data;
    logic [N_R-1:0]        r_valid;
    logic [N_W-1:0]        w_enable;
    logic [N_W*IW-1:0]     w_index;
    logic [N_W*DATA_W-1:0] w_data;
    logic [N_W*DATA_W-1:0] w_mask;
    logic                  oob_err;
    logic [31:0]           wr_count;

    modport master (
        output r_enable, r_index, w_enable, w_index, w_data, w_mask,
        input  r_data, r_valid, oob_err, wr_count
    );

    modport slave (
        input  r_enable, r_index, w_enable, w_index, w_data, w_mask,
        output r_data, r_valid, oob_err, wr_count
    );
endinterface

// File: rtl/mem_nr_mw_helper.sv
// mem_nr_mw_helper: N_R-read / N_W-write memory model with bit-masked writes,
// per-entry valid bits (unwritten entries read 0), RD_LAT-cycle read pipeline,
// optional same-cycle write-to-read forwarding, sticky out-of-range flag and a
// saturating accepted-write counter.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : mem_nr_mw_helper_if.slave (requests in, responses out)
module mem_nr_mw_helper #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned N_R    = 2,
    parameter int unsigned N_W    = 2,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned FWD    = 1
) (
    input  logic                clock,
    input  logic                reset,
    mem_nr_mw_helper_if.slave   bus
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned IW   = 64;
    localparam int unsigned LAST = RD_LAT - 1;

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
        $error("mem_nr_mw_helper: RD_LAT must be in 1..3");
    end
    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("mem_nr_mw_helper: DEPTH must be a power of two >= 2");
    end

    // Storage: data array is never reset; validity lives in ent_valid.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  ent_valid;

    logic              oob_q;
    logic [31:0]       cnt_q;
    logic [31:0]       cnt_next;

    logic              pipe_v [N_R][RD_LAT];
    logic [DATA_W-1:0] pipe_d [N_R][RD_LAT];

    // Write-port decode: an index is in range only when every bit at or above AW is zero.
    logic [N_W-1:0]    w_acc;
    logic [N_W-1:0]    w_oob;
    logic [AW-1:0]     w_addr [N_W];

    always_comb begin
        w_acc = '0;
        w_oob = '0;
        for (int j = 0; j < N_W; j++) begin
            w_addr[j] = bus.w_index[IW*j +: AW];
            if (bus.w_enable[j]) begin
                if (bus.w_index[IW*j+AW +: IW-AW] == '0) w_acc[j] = 1'b1;
                else                                     w_oob[j] = 1'b1;
            end
        end
    end

    // Read-port decode.
    logic [N_R-1:0]    r_inr;
    logic [N_R-1:0]    r_oob;
    logic [AW-1:0]     r_addr [N_R];

    always_comb begin
        r_inr = '0;
        r_oob = '0;
        for (int i = 0; i < N_R; i++) begin
            r_addr[i] = bus.r_index[IW*i +: AW];
            if (bus.r_index[IW*i+AW +: IW-AW] == '0) r_inr[i] = 1'b1;
            else if (bus.r_enable[i])                r_oob[i] = 1'b1;
        end
    end

    // Post-write value for each write port's entry: all colliding ports merge in
    // ascending order, so every port aimed at one entry carries the same result.
    logic [DATA_W-1:0] w_merged [N_W];

    always_comb begin
        for (int j = 0; j < N_W; j++) begin
            w_merged[j] = ent_valid[w_addr[j]] ? mem[w_addr[j]] : '0;
            for (int p = 0; p < N_W; p++) begin
                if (w_acc[p] && (w_addr[p] == w_addr[j])) begin
                    w_merged[j] = (w_merged[j] & ~bus.w_mask[DATA_W*p +: DATA_W])
                                | (bus.w_data[DATA_W*p +: DATA_W] & bus.w_mask[DATA_W*p +: DATA_W]);
                end
            end
        end
    end

    // Read sample: stored value, optionally with this cycle's writes folded in.
    logic [DATA_W-1:0] r_sample [N_R];

    always_comb begin
        for (int i = 0; i < N_R; i++) begin
            r_sample[i] = '0;
            if (r_inr[i]) begin
                r_sample[i] = ent_valid[r_addr[i]] ? mem[r_addr[i]] : '0;
                if (FWD != 0) begin
                    for (int p = 0; p < N_W; p++) begin
                        if (w_acc[p] && (w_addr[p] == r_addr[i])) begin
                            r_sample[i] = (r_sample[i] & ~bus.w_mask[DATA_W*p +: DATA_W])
                                        | (bus.w_data[DATA_W*p +: DATA_W] & bus.w_mask[DATA_W*p +: DATA_W]);
                        end
                    end
                end
            end
        end
    end

    // Saturating count of accepted writes.
    logic [32:0] cnt_sum;

    always_comb begin
        cnt_sum = {1'b0, cnt_q};
        for (int j = 0; j < N_W; j++) begin
            if (w_acc[j]) cnt_sum = cnt_sum + 33'd1;
        end
        cnt_next = cnt_sum[32] ? '1 : cnt_sum[31:0];
    end

    // Data array update; writes are held off while reset is asserted.
    always_ff @(posedge clock) begin
        for (int j = 0; j < N_W; j++) begin
            if (!reset && w_acc[j]) mem[w_addr[j]] <= w_merged[j];
        end
    end

    // Valid bits, flags and counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_valid <= '0;
            oob_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            for (int j = 0; j < N_W; j++) begin
                if (w_acc[j]) ent_valid[w_addr[j]] <= 1'b1;
            end
            if ((|w_oob) || (|r_oob)) oob_q <= 1'b1;
            cnt_q <= cnt_next;
        end
    end

    // Read pipeline; the last stage's data only loads on a valid result so
    // r_data holds the last delivered value between pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_R; i++) begin
                for (int s = 0; s < RD_LAT; s++) begin
                    pipe_v[i][s] <= 1'b0;
                    pipe_d[i][s] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N_R; i++) begin
                pipe_v[i][0] <= bus.r_enable[i];
                if (LAST != 0 || bus.r_enable[i]) pipe_d[i][0] <= r_sample[i];
                for (int unsigned s = 1; s < RD_LAT; s++) begin
                    pipe_v[i][s] <= pipe_v[i][s-1];
                    if (s != LAST || pipe_v[i][s-1]) pipe_d[i][s] <= pipe_d[i][s-1];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_R; i++) begin
            bus.r_valid[i]                  = pipe_v[i][LAST];
            bus.r_data[DATA_W*i +: DATA_W]  = pipe_d[i][LAST];
        end
        bus.oob_err  = oob_q;
        bus.wr_count = cnt_q;
    end
endmodule

// File: doc/mem_nr_mw_helper.md
Name: mem_nr_mw_helper

Overview:
Parametrised successor to the single-read/single-write memory helper used in the simulation harness. It provides N_R read ports and N_W write ports with bit-masked writes, a configurable read pipeline latency and optional write-to-read forwarding. Per-entry valid bits make unwritten or reset entries read as zero. A sticky out-of-range flag lets the harness catch bad indices. It sits behind DUT memory models in bugcase and difftest benches.

Parameters:
DATA_W, 64, data and mask width per port
DEPTH, 256, number of entries (power of two); AW = log2(DEPTH)
N_R, 2, number of read ports
N_W, 2, number of write ports
RD_LAT, 1, read latency in cycles (legal 1..3; elaborate-time error otherwise)
FWD, 1, 1 = same-cycle write data visible to reads; 0 = reads see pre-write contents

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high
r_enable  in  N_R  per-port read request
r_index  in  N_R*64  per-port entry index; port i in bits [64*i +: 64]
r_data  out  N_R*DATA_W  per-port read data
r_valid  out  N_R  one-cycle pulse, RD_LAT cycles after the accepted r_enable
w_enable  in  N_W  per-port write request
w_index  in  N_W*64  per-port entry index
w_data  in  N_W*DATA_W  per-port write data
w_mask  in  N_W*DATA_W  per-bit write enable (1 = write that bit)
oob_err  out  1  sticky: any enabled access used an index >= DEPTH
wr_count  out  32  number of accepted in-range writes, saturating

Behaviour:
- Reset (async assert): all entry valid bits cleared, read pipeline flushed, r_valid=0, r_data=0, oob_err=0, wr_count=0. Array data storage is not cleared; invalid entries read as 0.
- Out-of-range index: any bit of index at or above AW set.
  - Write: dropped; entry and valid bits untouched; not counted; oob_err set next edge.
  - Read: returns 0 with a normal r_valid pulse; oob_err set.
- Write, edge k with w_enable[j]=1 and in-range index:
  - Applied at edge k as entry = (base & ~mask) | (data & mask).
  - Base = stored value if the entry is valid, else 0.
  - Entry valid bit set even when mask=0.
  - wr_count += 1 per accepted port, saturating at 0xFFFFFFFF.
- Write collision, same index on several ports in one cycle: masks merge in ascending port order. Higher port index wins on overlapping bits; non-overlapping bits from all ports land.
- Read, r_enable[i]=1 in cycle k:
  - Value sampled in cycle k.
  - FWD=1: value equals the post-write result of cycle k, including collision merge.
  - FWD=0: value equals contents before cycle k's writes.
  - Delivered on r_data[i] with r_valid[i]=1 in cycle k+RD_LAT, i.e. after RD_LAT rising edges.
- Pipeline: RD_LAT-stage shift register per port carrying {valid, data}.
  - Back-to-back reads every cycle give one result per cycle, in order.
  - r_data holds its last delivered value when r_valid=0.
- Reads on different ports to the same index are independent and return identical data.
- r_enable=0: no pipeline slot is consumed; a bubble propagates.
- oob_err clears only on reset.
- Reset mid-operation: in-flight reads are discarded with no r_valid. The first read after deassertion behaves as from cold.

Test Plan:
1. Cold read: reset, then read idx 5 on port 0 with RD_LAT=1 -> next cycle r_valid[0]=1, r_data=0.
2. Masked write: write idx 3 data 0xFFFF_FFFF_FFFF_FFFF with mask 0x0000_0000_FFFF_0000 -> later read gives 0x0000_0000_FFFF_0000. Second write data 0x1234 mask 0xFFFF -> read gives 0x0000_0000_FFFF_1234. wr_count=2.
3. Collision: port0 writes idx 7 data 0xAAAA mask 0xFFFF while port1 writes idx 7 data 0x5500 mask 0xFF00 in the same cycle -> entry reads 0x55AA. wr_count += 2.
4. Forwarding: read and write idx 9 in the same cycle, write data 0xDEAD mask all-ones, old entry 0x1 -> FWD=1 returns 0xDEAD; FWD=0 returns 0x1.
5. Latency/throughput: RD_LAT=3, four consecutive reads of idx 0..3 holding values 10..13 -> r_valid high on cycles k+3..k+6 with data 10,11,12,13.
6. OOB and reset: write idx 0x100 with DEPTH=256 -> oob_err=1, wr_count unchanged, idx 0 unaffected. Assert reset with a read in flight -> no r_valid, oob_err=0, all entries read 0.
